// File: rtl/lsq_forward_queue.sv
// Load/store queue with age-ordered hazard bitmaps and store-to-load forwarding.
// Stores leave only after an in-order release from retire; flush keeps released stores.
module lsq_forward_queue #(
  parameter int LQ_DEPTH   = 4,
  parameter int SQ_DEPTH   = 4,
  parameter int ID_W       = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FORWARD_EN = 1,
  localparam int BE_W      = DATA_W / 8,
  localparam int LQ_CW     = $clog2(LQ_DEPTH) + 1,
  localparam int SQ_CW     = $clog2(SQ_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [BE_W-1:0]   in_be,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ID_W-1:0]   in_id,
  input  logic              store_release,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_load,
  output logic [ADDR_W-1:0] out_addr,
  output logic [BE_W-1:0]   out_be,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic              fwd_valid,
  output logic [ID_W-1:0]   fwd_id,
  output logic [DATA_W-1:0] fwd_data,
  output logic [LQ_CW-1:0]  lq_count,
  output logic [SQ_CW-1:0]  sq_count,
  output logic              empty
);

  localparam int LQ_AW = LQ_CW - 1;
  localparam int SQ_AW = SQ_CW - 1;
  localparam int OFF_W = $clog2(BE_W);

  // Control state
  logic [LQ_CW-1:0] lq_head_q, lq_head_d, lq_tail_q, lq_tail_d;
  logic [SQ_CW-1:0] sq_head_q, sq_head_d, sq_tail_q, sq_tail_d;
  logic [SQ_CW-1:0] rel_cnt_q, rel_cnt_d;
  logic             lock_q, lock_d, lock_load_q, lock_load_d;

  // Payload storage
  logic [ADDR_W-1:0]   sq_addr_q [SQ_DEPTH];
  logic [BE_W-1:0]     sq_be_q   [SQ_DEPTH];
  logic [DATA_W-1:0]   sq_data_q [SQ_DEPTH];
  logic [ID_W-1:0]     sq_id_q   [SQ_DEPTH];
  logic [ADDR_W-1:0]   lq_addr_q [LQ_DEPTH];
  logic [BE_W-1:0]     lq_be_q   [LQ_DEPTH];
  logic [ID_W-1:0]     lq_id_q   [LQ_DEPTH];
  logic [SQ_DEPTH-1:0] lq_bm_q   [LQ_DEPTH];
  logic [SQ_AW-1:0]    lq_fwd_q  [LQ_DEPTH];

  logic [LQ_AW-1:0]    lq_hidx, lq_tidx;
  logic [SQ_AW-1:0]    sq_hidx, sq_tidx;
  logic                lq_full, sq_full, push_load, push_store;
  logic                lq_pop, sq_pop, out_fire, sel_load;
  logic [SQ_DEPTH-1:0] sq_occ, ld_match, lq_bm_head;
  logic [SQ_AW-1:0]    new_fwd, lq_fwd_head;
  logic [BE_W-1:0]     lq_be_head;
  logic                ld_conflict, ld_issue, ld_fwd, st_rdy;

  // Youngest matching store: scan backwards from tail-1, nearest hit wins.
  function automatic logic [SQ_AW-1:0] youngest(input logic [SQ_DEPTH-1:0] bm,
                                                input logic [SQ_AW-1:0]    tail);
    logic [SQ_AW-1:0] idx;
    logic [SQ_AW-1:0] res;
    res = '0;
    for (int k = SQ_DEPTH; k >= 1; k--) begin
      idx = tail - SQ_AW'(k);
      if (bm[idx]) res = idx;
    end
    return res;
  endfunction

  assign lq_hidx  = lq_head_q[LQ_AW-1:0];
  assign lq_tidx  = lq_tail_q[LQ_AW-1:0];
  assign sq_hidx  = sq_head_q[SQ_AW-1:0];
  assign sq_tidx  = sq_tail_q[SQ_AW-1:0];
  assign lq_count = lq_tail_q - lq_head_q;
  assign sq_count = sq_tail_q - sq_head_q;
  assign empty    = (lq_count == '0) && (sq_count == '0);
  assign lq_full  = (lq_count == LQ_CW'(LQ_DEPTH));
  assign sq_full  = (sq_count == SQ_CW'(SQ_DEPTH));

  assign in_ready   = !(in_load && lq_full) && !(in_store && sq_full);
  assign push_load  = in_valid && in_ready && in_load && !flush;
  assign push_store = in_valid && in_ready && in_store && !flush;

  // Head-load classification
  assign lq_bm_head  = lq_bm_q[lq_hidx];
  assign lq_fwd_head = lq_fwd_q[lq_hidx];
  assign lq_be_head  = lq_be_q[lq_hidx];
  assign ld_conflict = |lq_bm_head;
  assign ld_issue    = (lq_count != '0) && !ld_conflict;
  assign ld_fwd      = (FORWARD_EN != 0) && (lq_count != '0) && ld_conflict &&
                       lq_bm_head[lq_fwd_head] &&
                       ((lq_be_head & ~sq_be_q[lq_fwd_head]) == '0);
  assign st_rdy      = (rel_cnt_q != '0);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    out_valid = 1'b0;
    out_load  = 1'b0;
    out_addr  = '0;
    out_be    = '0;
    out_data  = '0;
    out_id    = '0;
    sel_load  = 1'b0;
    if (lock_q) begin
      out_valid = 1'b1;
      sel_load  = lock_load_q;
    end else if (ld_issue) begin
      out_valid = 1'b1;
      sel_load  = 1'b1;
    end else if (st_rdy) begin
      out_valid = 1'b1;
    end
    if (out_valid) begin
      out_load = sel_load;
      if (sel_load) begin
        out_addr = lq_addr_q[lq_hidx];
        out_be   = lq_be_head;
        out_id   = lq_id_q[lq_hidx];
      end else begin
        out_addr = sq_addr_q[sq_hidx];
        out_be   = sq_be_q[sq_hidx];
        out_data = sq_data_q[sq_hidx];
        out_id   = sq_id_q[sq_hidx];
      end
    end
  end

  assign out_fire = out_valid && out_ready;
  assign sq_pop   = out_fire && !sel_load;
  assign lq_pop   = ld_fwd || (out_fire && sel_load);

  always_comb begin
    fwd_valid = ld_fwd;
    fwd_id    = '0;
    fwd_data  = '0;
    if (ld_fwd) begin
      fwd_id = lq_id_q[lq_hidx];
      for (int b = 0; b < BE_W; b++)
        fwd_data[8*b +: 8] = lq_be_head[b] ? sq_data_q[lq_fwd_head][8*b +: 8] : 8'h00;
    end
  end

  // Conflict snapshot for an incoming load; a store leaving this cycle is excluded.
  always_comb begin
    for (int i = 0; i < SQ_DEPTH; i++) begin
      sq_occ[i]   = ({1'b0, SQ_AW'(i) - sq_hidx} < sq_count);
      ld_match[i] = sq_occ[i] &&
                    (sq_addr_q[i][ADDR_W-1:OFF_W] == in_addr[ADDR_W-1:OFF_W]) &&
                    !(sq_pop && (sq_hidx == SQ_AW'(i)));
    end
    new_fwd = youngest(ld_match, sq_tidx);
  end

  always_comb begin
    lq_head_d   = lq_head_q + LQ_CW'(lq_pop);
    lq_tail_d   = lq_tail_q + LQ_CW'(push_load);
    sq_head_d   = sq_head_q + SQ_CW'(sq_pop);
    sq_tail_d   = sq_tail_q + SQ_CW'(push_store);
    rel_cnt_d   = rel_cnt_q + SQ_CW'(store_release) - SQ_CW'(sq_pop);
    lock_d      = out_valid && !out_ready;
    lock_load_d = sel_load;
    if (flush) begin
      lq_tail_d = lq_head_d;
      sq_tail_d = sq_head_d + rel_cnt_d;
      if (sel_load) lock_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lq_head_q   <= '0;
      lq_tail_q   <= '0;
      sq_head_q   <= '0;
      sq_tail_q   <= '0;
      rel_cnt_q   <= '0;
      lock_q      <= 1'b0;
      lock_load_q <= 1'b0;
    end else begin
      lq_head_q   <= lq_head_d;
      lq_tail_q   <= lq_tail_d;
      sq_head_q   <= sq_head_d;
      sq_tail_q   <= sq_tail_d;
      rel_cnt_q   <= rel_cnt_d;
      lock_q      <= lock_d;
      lock_load_q <= lock_load_d;
    end
  end

  // NOTE: payload arrays carry no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_store) begin
      sq_addr_q[sq_tidx] <= in_addr;
      sq_be_q[sq_tidx]   <= in_be;
      sq_data_q[sq_tidx] <= in_data;
      sq_id_q[sq_tidx]   <= in_id;
    end
    if (push_load) begin
      lq_addr_q[lq_tidx] <= in_addr;
      lq_be_q[lq_tidx]   <= in_be;
      lq_id_q[lq_tidx]   <= in_id;
      lq_fwd_q[lq_tidx]  <= new_fwd;
    end
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (push_load && (lq_tidx == LQ_AW'(i))) lq_bm_q[i] <= ld_match;
      else if (sq_pop)                          lq_bm_q[i][sq_hidx] <= 1'b0;
    end
  end

  // Retire may only release a store that exists and is not yet released.
  release_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
    store_release |-> (rel_cnt_q < sq_count));

endmodule
